dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, byte-address width of both requester ports and the memory port.
REQ-002 Parameter MAX_LOCK, default 15, maximum consecutive grants to port 1 while its lock is held.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 p0_req / p1_req  input  1  access request from port 0 (processor load/store) / port 1 (debug/loader).
REQ-006 pN_we  input  1  write enable; pN_addr  input  AW  byte address; pN_wdata  input  32  write data; pN_wstrb  input  4  byte lanes.
REQ-007 p1_lock  input  1  port 1 requests back-to-back ownership (burst fill).
REQ-008 pN_gnt  output  1  request accepted this cycle.
REQ-009 pN_rvalid  output  1  read data valid; pN_rdata  output  32  read data.
REQ-010 mem_en, mem_we  output  1; mem_addr  output  AW; mem_wdata  output  32; mem_wstrb  output  4  single-port memory command.
REQ-011 mem_rdata  input  32  memory read data, valid one cycle after a read command.

Function
REQ-012 A request is accepted (pN_gnt=1) in the same cycle it is sampled; gnt is combinational from req and arbiter state.
REQ-013 At most one gnt per cycle; mem_en equals OR of the gnts; mem command fields mux from the granted port, zero when idle.
REQ-014 Read latency is exactly 1: accepted read at cycle N gives pN_rvalid=1, pN_rdata=mem_rdata at N+1, to the original port only.
REQ-015 Writes produce no rvalid; mem_wstrb passes through; mem_we=0 forces mem_wstrb=0.
REQ-016 Back-to-back accesses are permitted: a new grant may issue in the same cycle as the previous rvalid.
REQ-017 FSM states: IDLE (no owner), OWN0 (last grant port 0), OWN1 (last grant port 1), LOCK1 (port 1 burst).
REQ-018 Transitions: grant0 -> OWN0; grant1 with p1_lock=0 -> OWN1; grant1 with p1_lock=1 -> LOCK1; no grant -> IDLE.
REQ-019 In LOCK1 only port 1 may be granted; leave LOCK1 when p1_lock drops, p1_req drops, or lock counter reaches MAX_LOCK.
REQ-020 Lock counter: 4-bit, cleared on entry to LOCK1, increments per port-1 grant in LOCK1, saturates; on MAX_LOCK, next state is OWN1 and port 0 wins if requesting.
REQ-021 Simultaneous requests outside LOCK1: priority per REQ-029/REQ-030.
REQ-022 rvalid outputs are zero when the previous cycle issued no read; rdata holds mem_rdata unconditionally.

Reset
REQ-023 On reset: state IDLE, lock counter 0, rvalid pipeline flags 0, round-robin pointer to port 0.
REQ-024 All outputs 0 during reset cycles; no gnt or mem_en issued while reset=1 regardless of requests.
REQ-025 Reset asserted mid-read cancels the pending rvalid; no rvalid appears in the cycle after reset.

Configuration
REQ-026 Macro DMEM_ARB_ROUND_ROBIN_EN selects the arbitration policy outside LOCK1.
REQ-027 Defined: one-bit pointer toggles to the non-granted port after each contested grant; the port not served last wins a tie.
REQ-028 Undefined: pointer logic removed; fixed priority.
REQ-029 Undefined policy: port 0 always wins a tie.
REQ-030 Defined policy: tie won by port != last granted; uncontested request always granted.

Structure
REQ-031 Shared package salaga_pkg holds the FSM state enumeration (2-bit encoding), port index constants, and MEM_DW=32.
REQ-032 One sub-module arb_lock_counter (saturating counter with clear/increment/at_max) is instantiated once; the rest is flat.

Verification
REQ-033 Reset 5 cycles with p0_req=p1_req=1 -> no gnt, mem_en=0, all rvalid=0 throughout.
REQ-034 p0 read addr 0x8 with mem holding 0xDEADBEEF -> p0_gnt at N, p0_rvalid=1, p0_rdata=0xDEADBEEF at N+1, p1_rvalid=0.
REQ-035 Both request continuously, no lock -> without macro all 10 grants to p0; with macro grants alternate p0,p1,p0,...
REQ-036 p1_lock=1 and p1_req=1 for 20 cycles, p0_req=1 -> 15 consecutive p1 grants, then p0 granted at grant 16.
REQ-037 p1 write 0x12345678 wstrb 0x3 to 0x4, then p0 read 0x4 next cycle -> mem_wstrb=0x3 on write, p0_rvalid one cycle after its grant, no p1_rvalid.
REQ-038 Reset asserted the cycle after p0 read grant -> p0_rvalid stays 0, state IDLE.

Source files
------------

// File: rtl/salaga_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and memory data widths.
package salaga_pkg;

   localparam int unsigned MEM_DW     = 32;
   localparam int unsigned STRB_W     = MEM_DW / 8;
   localparam int unsigned LOCK_CNT_W = 4;

   localparam int unsigned PORT0 = 0;
   localparam int unsigned PORT1 = 1;

   // Arbiter ownership state
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_LOCK1 = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_lock_counter.sv
// Saturating burst-length counter for the port-1 lock.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_clear     - restart the count (start of a new burst)
//   i_inc       - count one grant (combined with i_clear the burst starts at 1)
//   o_at_max_c  - the next counted grant reaches MAX (last grant of the burst)
module arb_lock_counter
   import salaga_pkg::*;
#(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_at_max_c
);

   logic [LOCK_CNT_W-1:0] r_count;

   // Count of grants in the current burst, saturating at MAX
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= i_inc ? LOCK_CNT_W'(1) : '0;
      end else if (i_inc && (32'(r_count) < MAX)) begin
         r_count <= r_count + LOCK_CNT_W'(1);
      end
   end

   assign o_at_max_c = (32'(r_count) + 32'd1) >= MAX;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory. Port 0 is the
// processor load/store port, port 1 the debug/loader port which may lock
// the memory for a burst of up to MAX_LOCK back-to-back grants.
// Grants are combinational; read data returns one cycle after the grant.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// outside a lock burst; when undefined port 0 always wins a tie.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   pN_req/we/addr/wdata/wstrb         - requester command, N = 0, 1
//   p1_lock                            - port 1 wants back-to-back ownership
//   pN_gnt                             - request accepted this cycle
//   pN_rvalid, pN_rdata                - read response
//   mem_en/we/addr/wdata/wstrb         - memory command
//   mem_rdata                          - memory read data (1-cycle latency)
module dmem_arbiter
   import salaga_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned MAX_LOCK = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [AW-1:0]     p0_addr,
   input  logic [MEM_DW-1:0] p0_wdata,
   input  logic [STRB_W-1:0] p0_wstrb,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [AW-1:0]     p1_addr,
   input  logic [MEM_DW-1:0] p1_wdata,
   input  logic [STRB_W-1:0] p1_wstrb,
   input  logic              p1_lock,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic [MEM_DW-1:0] p0_rdata,
   output logic              p1_rvalid,
   output logic [MEM_DW-1:0] p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [MEM_DW-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic [MEM_DW-1:0] mem_rdata
);

   arb_state_t r_state;
   arb_state_t w_state_next;
   logic       w_req0;
   logic       w_req1;
   logic       w_gnt0;
   logic       w_gnt1;
   logic       w_pick1;
   logic       w_cnt_clear;
   logic       w_cnt_inc;
   logic       w_at_max;
   logic       r_rvalid0;
   logic       r_rvalid1;

   // Requests are ignored while reset is held
   assign w_req0 = p0_req & ~reset;
   assign w_req1 = p1_req & ~reset;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic r_rr_ptr;

   // Tie-break pointer: after a contested grant, favour the other port
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= 1'(PORT0);
      end else if (w_req0 && w_req1 && (w_gnt0 || w_gnt1)) begin
         r_rr_ptr <= w_gnt0 ? 1'(PORT1) : 1'(PORT0);
      end
   end

   assign w_pick1 = r_rr_ptr;
`else
   assign w_pick1 = 1'b0;
`endif

   arb_lock_counter #(
      .MAX        (MAX_LOCK)
   ) u_lock_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_cnt_clear),
      .i_inc      (w_cnt_inc),
      .o_at_max_c (w_at_max)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grant selection and next state
   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_cnt_clear  = 1'b0;
      w_cnt_inc    = 1'b0;
      w_state_next = ST_IDLE;
      if (r_state == ST_LOCK1) begin
         // Port 1 owns the memory; port 0 waits even if port 1 is idle
         if (w_req1) begin
            w_gnt1 = 1'b1;
            if (p1_lock && !w_at_max) begin
               w_cnt_inc    = 1'b1;
               w_state_next = ST_LOCK1;
            end else begin
               w_state_next = ST_OWN1;
            end
         end
      end else begin
         if (w_req0 && w_req1) begin
            w_gnt1 = w_pick1;
            w_gnt0 = ~w_pick1;
         end else begin
            w_gnt0 = w_req0;
            w_gnt1 = w_req1;
         end
         if (w_gnt0) begin
            w_state_next = ST_OWN0;
         end else if (w_gnt1) begin
            // The entering grant is the first grant of the burst
            if (p1_lock && (MAX_LOCK > 1)) begin
               w_cnt_clear  = 1'b1;
               w_cnt_inc    = 1'b1;
               w_state_next = ST_LOCK1;
            end else begin
               w_state_next = ST_OWN1;
            end
         end
      end
   end

   assign p0_gnt = w_gnt0;
   assign p1_gnt = w_gnt1;
   assign mem_en = w_gnt0 | w_gnt1;

   // Memory command mux; all-zero when idle, strobes only on writes
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (w_gnt0) begin
         mem_we    = p0_we;
         mem_addr  = p0_addr;
         mem_wdata = p0_wdata;
         mem_wstrb = p0_we ? p0_wstrb : '0;
      end else if (w_gnt1) begin
         mem_we    = p1_we;
         mem_addr  = p1_addr;
         mem_wdata = p1_wdata;
         mem_wstrb = p1_we ? p1_wstrb : '0;
      end
   end

   // Read-return flags: one cycle after a granted read, to its port
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 & ~p0_we;
         r_rvalid1 <= w_gnt1 & ~p1_we;
      end
   end

   // Outputs held at zero while reset is asserted
   assign p0_rvalid = r_rvalid0 & ~reset;
   assign p1_rvalid = r_rvalid1 & ~reset;
   assign p0_rdata  = reset ? '0 : mem_rdata;
   assign p1_rdata  = reset ? '0 : mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Read responses are checked by a
// scoreboard queue; grants and memory commands are checked inline.
// Honours DMEM_ARB_ROUND_ROBIN_EN for the expected tie-break policy.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;

   logic          clk;
   logic          reset;
   logic          p0_req, p0_we;
   logic [AW-1:0] p0_addr;
   logic [31:0]   p0_wdata;
   logic [3:0]    p0_wstrb;
   logic          p1_req, p1_we, p1_lock;
   logic [AW-1:0] p1_addr;
   logic [31:0]   p1_wdata;
   logic [3:0]    p1_wstrb;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0]   p0_rdata, p1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_rdata;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks;
   int          errors;
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];

   dmem_arbiter #(.AW(AW), .MAX_LOCK(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_wstrb  (p0_wstrb),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_wstrb  (p1_wstrb),
      .p1_lock   (p1_lock),
      .p0_gnt    (p0_gnt),
      .p1_gnt    (p1_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory, 1-cycle read latency, byte-lane writes
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr[7:2]];
         end
      end
   end

   // Scoreboard: every rvalid must match the oldest outstanding read
   always @(negedge clk) begin
      if (p0_rvalid || p1_rvalid) begin
         checks++;
         if (p0_rvalid && p1_rvalid) begin
            errors++;
            $display("FAIL rvalid_both: p0_rvalid=1 p1_rvalid=1, required one at a time");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected: p0_rvalid=%0b p1_rvalid=%0b, required none", p0_rvalid, p1_rvalid);
         end else begin
            mon_e = exp_q.pop_front();
            if (p1_rvalid !== mon_e.port || (p1_rvalid ? p1_rdata : p0_rdata) !== mon_e.data) begin
               errors++;
               $display("FAIL rvalid_data: port %0d data %h, required port %0d data %h",
                        p1_rvalid, p1_rvalid ? p1_rdata : p0_rdata, mon_e.port, mon_e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
      p1_lock = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p0_req = 1; p1_req = 1; p1_lock = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_quiet cycle %0d: gnt0,gnt1,en,rv0,rv1=%b, required 00000",
                     c, {p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid});
         end
         step();
      end
      idle_inputs();
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_read();
      p0_req = 1; p0_addr = 32'h8;
      @(negedge clk);
      checks++;
      if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_en !== 1'b1) begin
         errors++;
         $display("FAIL read_grant: gnt0=%b gnt1=%b en=%b, required 1 0 1", p0_gnt, p1_gnt, mem_en);
      end
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h8 || mem_wstrb !== 4'h0) begin
         errors++;
         $display("FAIL read_cmd: we=%b addr=%h wstrb=%h, required 0 00000008 0", mem_we, mem_addr, mem_wstrb);
      end
      exp_q.push_back('{port: 1'b0, data: ref_mem[2]});
      step();
      p0_req = 0;
      @(negedge clk);
      checks++;
      if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL read_rvalid: rv0=%b rv1=%b, required 1 0", p0_rvalid, p1_rvalid);
      end
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL read_drain: %0d reads outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_contention();
      bit exp1;
      do_reset();
      p0_req = 1; p0_addr = 32'h10;
      p1_req = 1; p1_addr = 32'h14;
      for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         exp1 = (i % 2) == 1;
`else
         exp1 = 1'b0;
`endif
         @(negedge clk);
         checks++;
         if ({p0_gnt, p1_gnt} !== (exp1 ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL contend_grant %0d: gnt0,gnt1=%b, required %b",
                     i, {p0_gnt, p1_gnt}, exp1 ? 2'b01 : 2'b10);
         end
         exp_q.push_back('{port: exp1, data: ref_mem[exp1 ? 5 : 4]});
         step();
      end
      idle_inputs();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL contend_drain: %0d reads outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_lock();
      bit exp1;
      do_reset();
      p1_req = 1; p1_lock = 1; p1_addr = 32'h20;
      p0_addr = 32'h24;
      for (int i = 0; i < 16; i++) begin
         if (i == 1) p0_req = 1;
         exp1 = (i < 15);
         @(negedge clk);
         checks++;
         if ({p0_gnt, p1_gnt} !== (exp1 ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL lock_grant %0d: gnt0,gnt1=%b, required %b",
                     i + 1, {p0_gnt, p1_gnt}, exp1 ? 2'b01 : 2'b10);
         end
         exp_q.push_back('{port: exp1, data: ref_mem[exp1 ? 8 : 9]});
         step();
      end
      idle_inputs();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL lock_drain: %0d reads outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      p1_req = 1; p1_we = 1; p1_addr = 32'h4; p1_wdata = 32'h12345678; p1_wstrb = 4'h3;
      @(negedge clk);
      checks++;
      if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
         errors++;
         $display("FAIL write_grant: gnt0=%b gnt1=%b, required 0 1", p0_gnt, p1_gnt);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_wstrb !== 4'h3 || mem_addr !== 32'h4 || mem_wdata !== 32'h12345678) begin
         errors++;
         $display("FAIL write_cmd: we=%b wstrb=%h addr=%h wdata=%h, required 1 3 00000004 12345678",
                  mem_we, mem_wstrb, mem_addr, mem_wdata);
      end
      ref_mem[1][15:0] = 16'h5678;
      step();
      idle_inputs();
      p0_req = 1; p0_addr = 32'h4; p0_wstrb = 4'hF;
      @(negedge clk);
      checks++;
      if (p0_gnt !== 1'b1 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL b2b_read: gnt0=%b we=%b wstrb=%h, required 1 0 0", p0_gnt, mem_we, mem_wstrb);
      end
      exp_q.push_back('{port: 1'b0, data: ref_mem[1]});
      step();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_rvalid: rv0=%b rv1=%b, required 1 0", p0_rvalid, p1_rvalid);
      end
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: %0d reads outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_read();
      p0_req = 1; p0_addr = 32'h8;
      @(negedge clk);
      checks++;
      if (p0_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midrst_grant: gnt0=%b, required 1", p0_gnt);
      end
      step();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_during: rv0=%b rv1=%b en=%b, required 0 0 0", p0_rvalid, p1_rvalid, mem_en);
      end
      step();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after: rv0=%b rv1=%b, required 0 0", p0_rvalid, p1_rvalid);
      end
      step();
      // After reset an uncontested port-1 request is granted straight away
      p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wstrb = 4'h0;
      @(negedge clk);
      checks++;
      if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle: gnt0=%b gnt1=%b, required 0 1", p0_gnt, p1_gnt);
      end
      step();
      idle_inputs();
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hC0DE0000 | 32'(i);
         ref_mem[i] = 32'hC0DE0000 | 32'(i);
      end
      mem[2]     = 32'hDEADBEEF;
      ref_mem[2] = 32'hDEADBEEF;
      idle_inputs();
      reset = 1'b1;

      test_reset();
      test_single_read();
      test_contention();
      test_lock();
      test_back_to_back();
      test_reset_mid_read();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
